i2c_apb_cmd_sequencer: RTL

//   APB master front-end that shares the I2C controller's APB register port between NREQ command

---
 rtl/i2c_apb_cmd_sequencer.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/i2c_apb_cmd_sequencer.sv
// Round-robin APB master that shares the I2C controller register port between NREQ command sources.
// Zero-wait transfer takes 4 cycles (IDLE, SETUP, ACCESS, RESP). Requesters hold req_valid until their req_ready pulse.
// Wait states stretch ACCESS, and a pready timeout forces an error response.
module i2c_apb_cmd_sequencer #(
    parameter int NREQ    = 2,
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int TIMEOUT = 255
) (
    input  logic               pclk,
    input  logic               presetn,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ-1:0]    req_write,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    req_ready,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [DW-1:0]      rsp_rdata,
    output logic               rsp_err,
    output logic               busy,
    output logic               psel,
    output logic               penable,
    output logic               pwrite,
    output logic [AW-1:0]      paddr,
    output logic [DW-1:0]      pwdata,
    input  logic               pready,
    input  logic [DW-1:0]      prdata,
    input  logic               pslverr
);

    localparam int RW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } cmd_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   rr_q, rr_d;
    logic [RW-1:0]   gnt_q, gnt_d;
    cmd_t            cmd_q, cmd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] req_ready_q, req_ready_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic            rsp_err_q, rsp_err_d;
    logic            busy_q, busy_d;
    logic            psel_q, psel_d;
    logic            penable_q, penable_d;
    logic            pwrite_q, pwrite_d;
    logic [AW-1:0]   paddr_q, paddr_d;
    logic [DW-1:0]   pwdata_q, pwdata_d;

    logic [RW-1:0]   arb_idx;
    logic            arb_hit;
    int              cand;
    cmd_t            arb_cmd;

    // Search upward from the pointer, wrapping; first pending requester wins.
    always_comb begin
        arb_idx = '0;
        arb_hit = 1'b0;
        cand    = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand = int'(rr_q) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!arb_hit && req_valid[cand]) begin
                arb_hit = 1'b1;
                arb_idx = RW'(cand);
            end
        end
        arb_cmd.wr    = req_write[arb_idx];
        arb_cmd.addr  = req_addr[arb_idx*AW +: AW];
        arb_cmd.wdata = req_wdata[arb_idx*DW +: DW];
    end

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        gnt_d       = gnt_q;
        cmd_d       = cmd_q;
        cnt_d       = cnt_q;
        req_ready_d = '0;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        psel_d      = 1'b0;
        penable_d   = 1'b0;
        pwrite_d    = 1'b0;
        paddr_d     = '0;
        pwdata_d    = '0;

        case (state_q)
            IDLE: begin
                if (arb_hit) begin
                    gnt_d                = arb_idx;
                    cmd_d                = arb_cmd;
                    rr_d                 = (arb_idx == RW'(NREQ - 1)) ? '0 : arb_idx + RW'(1);
                    req_ready_d[arb_idx] = 1'b1;
                    psel_d               = 1'b1;
                    pwrite_d             = arb_cmd.wr;
                    paddr_d              = arb_cmd.addr;
                    pwdata_d             = arb_cmd.wdata;
                    state_d              = SETUP;
                end
            end
            SETUP: begin
                psel_d    = 1'b1;
                penable_d = 1'b1;
                pwrite_d  = cmd_q.wr;
                paddr_d   = cmd_q.addr;
                pwdata_d  = cmd_q.wdata;
                state_d   = ACCESS;
            end
            ACCESS: begin
                // A late pready on the final allowed cycle still completes normally.
                if (pready) begin
                    rsp_rdata_d        = cmd_q.wr ? '0 : prdata;
                    rsp_err_d          = pslverr;
                    rsp_valid_d[gnt_q] = 1'b1;
                    state_d            = RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    rsp_rdata_d        = '0;
                    rsp_err_d          = 1'b1;
                    rsp_valid_d[gnt_q] = 1'b1;
                    state_d            = RESP;
                end else begin
                    cnt_d     = cnt_q + CW'(1);
                    psel_d    = 1'b1;
                    penable_d = 1'b1;
                    pwrite_d  = cmd_q.wr;
                    paddr_d   = cmd_q.addr;
                    pwdata_d  = cmd_q.wdata;
                end
            end
            RESP: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state_q     <= IDLE;
            rr_q        <= '0;
            gnt_q       <= '0;
            cmd_q       <= '0;
            cnt_q       <= '0;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            gnt_q       <= gnt_d;
            cmd_q       <= cmd_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;

endmodule
